// File: rtl/cpu_register_file_if.sv
// Register-file access bus: write port, shared address, and the read/immediate output.
interface cpu_register_file_if #(
    parameter int unsigned pointer_width = 3
);
    logic                     write_enable;
    logic [pointer_width-1:0] address;
    logic [7:0]               data_in;
    logic                     is_immediate;
    logic [7:0]               data_out;

    // Datapath side drives the request and consumes the operand.
    modport master (
        output write_enable,
        output address,
        output data_in,
        output is_immediate,
        input  data_out
    );

    // Register file side.
    modport slave (
        input  write_enable,
        input  address,
        input  data_in,
        input  is_immediate,
        output data_out
    );
endinterface

// File: rtl/cpu_register_file.sv
// General-purpose 8-bit register file with a single shared address.
// The address either indexes a register or, in immediate mode, is the
// operand itself (zero-extended). Writes are synchronous; reads are combinational.
module cpu_register_file #(
    parameter int unsigned pointer_width = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    cpu_register_file_if.slave bus
);
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned NUM_REGS = 1 << pointer_width;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage: async clear, then a single-register write per enabled edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.write_enable) begin
            regs_q[bus.address] <= bus.data_in;
        end
    end

    // Output select: stored value (no write bypass) or zero-extended address.
    always_comb begin
        bus.data_out = '0;
        if (bus.is_immediate) begin
            bus.data_out = DATA_W'(bus.address);
        end else begin
            bus.data_out = regs_q[bus.address];
        end
    end
endmodule

// File: tb/tb_cpu_register_file.sv
// Directed, table-driven bench for cpu_register_file (pointer_width = 3).
module tb_cpu_register_file;
    localparam int unsigned PW = 3;

    logic clock;
    logic reset_n;

    cpu_register_file_if #(.pointer_width(PW)) bus ();

    cpu_register_file #(.pointer_width(PW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic          we;
        logic [PW-1:0] addr;
        logic [7:0]    din;
        logic          imm;
        logic [7:0]    exp;   // data_out expected before this vector's clock edge
        string         name;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] exp);
        n_cmp++;
        if (bus.data_out !== exp) begin
            n_fail++;
            $display("FAIL %s: data_out=%h expected=%h (t=%0t)", name, bus.data_out, exp, $time);
        end
    endtask

    task automatic add(input logic we, input logic [PW-1:0] addr, input logic [7:0] din,
                       input logic imm, input logic [7:0] exp, input string name);
        vec_t v;
        v.we = we; v.addr = addr; v.din = din; v.imm = imm; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive after a falling edge, check mid-cycle, then let the rising edge act.
    task automatic apply(input vec_t v);
        bus.write_enable = v.we;
        bus.address      = v.addr;
        bus.data_in      = v.din;
        bus.is_immediate = v.imm;
        #1;
        check(v.name, v.exp);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // Fill regs[i] = 7-i; before each write edge the register still reads 0.
        for (int i = 0; i < 8; i++) add(1'b1, PW'(i), 8'(7 - i), 1'b0, 8'h00, "fill_pre");
        // Readback sweep.
        for (int i = 0; i < 8; i++) add(1'b0, PW'(i), 8'hEE, 1'b0, 8'(7 - i), "readback");
        // Last-write visibility: old value shown until the edge, new value after.
        add(1'b1, 3'd7, 8'h5A, 1'b0, 8'h00, "r7_pre_5a");
        add(1'b1, 3'd7, 8'h00, 1'b0, 8'h5A, "r7_old_before_edge");
        add(1'b0, 3'd7, 8'hFF, 1'b0, 8'h00, "r7_after_write0");
        // Immediate sweep, independent of stored contents.
        for (int i = 0; i < 8; i++) add(1'b0, PW'(i), 8'hC3, 1'b1, 8'(i), "immediate");
        // Write inhibit on reg 2 (holds 5).
        for (int i = 0; i < 3; i++) add(1'b0, 3'd2, 8'hAA, 1'b0, 8'h05, "inhibit_r2");
        // Write during immediate mode, then read it back in register mode.
        add(1'b1, 3'd3, 8'h3C, 1'b1, 8'h03, "imm_write_shows_imm");
        add(1'b0, 3'd3, 8'h00, 1'b1, 8'h03, "imm_after_write");
        add(1'b0, 3'd3, 8'h00, 1'b0, 8'h3C, "reg_after_imm_write");
        // Register 0 is ordinary storage.
        add(1'b1, 3'd0, 8'h81, 1'b0, 8'h07, "r0_pre");
        add(1'b0, 3'd0, 8'h00, 1'b0, 8'h81, "r0_writable");
        add(1'b0, 3'd2, 8'h00, 1'b0, 8'h05, "r2_untouched");

        // Power-on reset, released between edges.
        reset_n          = 1'b0;
        bus.write_enable = 1'b0;
        bus.address      = '0;
        bus.data_in      = '0;
        bus.is_immediate = 1'b0;
        #2;
        for (int a = 0; a < 8; a++) begin
            bus.address = PW'(a);
            #1;
            check("por_reset_read", 8'h00);
        end
        #2 reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous mid-run reset, not aligned to any edge; write requested throughout.
        #2;
        reset_n          = 1'b0;
        bus.write_enable = 1'b1;
        bus.data_in      = 8'hFF;
        bus.is_immediate = 1'b0;
        for (int a = 0; a < 8; a++) begin
            bus.address = PW'(a);
            #1;
            check("async_reset_read", 8'h00);
        end
        bus.is_immediate = 1'b1;
        bus.address      = 3'd6;
        #1;
        check("reset_imm_passthru", 8'h06);
        @(negedge clock);
        #2;
        reset_n          = 1'b1;
        bus.write_enable = 1'b0;
        bus.is_immediate = 1'b0;
        bus.address      = 3'd5;
        #1;
        check("no_write_during_reset", 8'h00);

        // First write lands on the first rising edge after release.
        bus.write_enable = 1'b1;
        bus.address      = 3'd1;
        bus.data_in      = 8'h77;
        #1;
        check("first_write_pre", 8'h00);
        @(posedge clock);
        #1;
        bus.write_enable = 1'b0;
        #1;
        check("first_write_post", 8'h77);
        bus.address = 3'd0;
        #1;
        check("r0_cleared_by_reset", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_register_file.md
Name: cpu_register_file

Overview:
General-purpose 8-bit register file for the CPU datapath, with 2**pointer_width registers behind a single shared address. The address either selects a register or is itself the operand. When is_immediate is 1, the address bits are output as a zero-extended immediate. Writes are synchronous; the read/immediate output path is combinational.

Parameters:
pointer_width, 3, register address width in bits; register count = 2**pointer_width; legal range 1..8.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous active-low reset; clears every register.
write_enable  input  1  when 1, data_in is written to regs[address] at the rising clock edge.
address  input  pointer_width  register index (write and read), or immediate value when is_immediate=1.
data_in  input  8  write data.
is_immediate  input  1  output select: 0 = register contents, 1 = zero-extended address.
data_out  output  8  read data or immediate.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-low (reset_n).
- Storage: 2**pointer_width registers, each 8 bits, indexed 0..2**pointer_width-1.
- Reset: while reset_n=0, all registers are 0, independent of clock. With is_immediate=0, data_out=0 during reset. With is_immediate=1, data_out is still the immediate.
- Reset release: the first write can occur at the first rising edge after reset_n returns to 1.
- Write timing:
  - At a rising clock edge with reset_n=1 and write_enable=1, regs[address] <= data_in.
  - Exactly one register is written; all others hold.
  - A write occurs regardless of is_immediate.
- No write: write_enable=0 leaves every register unchanged.
- Read path (combinational, zero cycle latency):
  - is_immediate=0: data_out = regs[address].
  - is_immediate=1: data_out = {(8-pointer_width) zeros, address}; register contents are not involved.
- Read-during-write: data_out shows the old value of regs[address] until the write edge. From that edge on it shows the new value, one cycle after data_in was presented. There is no write-to-read bypass.
- Register 0 is an ordinary writable register; it is not hard-wired to zero.
- Address range: every address value is valid (full power-of-two range), so no out-of-range case exists.
- Timing: data_out must settle within the same cycle after address or is_immediate change. No X propagation after reset.

Test Plan:
1. Reset: pulse reset_n low mid-simulation (asynchronous, not clock-aligned), is_immediate=0 -> data_out=0 for addresses 0..7 with no clock edge needed.
2. Fill/readback, pointer_width=3: write regs[i] = 7-i for i=0..7, one per edge, with write_enable=1. Then set write_enable=0, is_immediate=0, sweep address 0..7 -> data_out = 7,6,5,4,3,2,1,0.
3. Last write visibility: write data_in=0 to address 7. On the following cycle, with write_enable=0 and address=7 -> data_out=0. Before that write edge, data_out showed the prior contents.
4. Immediate mode: is_immediate=1, sweep address 0..7 -> data_out=0..7 (zero-extended), independent of stored values.
5. Write inhibit: write_enable=0, address=2, data_in=8'hAA, clock several edges -> regs[2] unchanged (still 5).
6. Write while immediate: is_immediate=1, write_enable=1, address=3, data_in=8'h3C, one edge -> data_out=3 during immediate mode. Switching is_immediate to 0 -> data_out=8'h3C.
